// File: rtl/farrow_pkg.sv
// Shared types and fixed-point helpers for the Farrow coefficient evaluator.
// Helpers work on 64-bit signed values; callers sign-extend and truncate.
package farrow_pkg;

   typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Clamp x into the signed range of a w-bit two's complement number.
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      return x;
   endfunction

   // Round-half-up arithmetic right shift by sh bits (sh >= 1).
   function automatic logic signed [63:0] round_shr(input logic signed [63:0] x, input int sh);
      return (x + (64'sd1 <<< (sh - 1))) >>> sh;
   endfunction

endpackage

// File: rtl/farrow_horner_step.sv
// One Horner iteration for a single tap: acc*mu (rounded back to coefficient
// scale) plus the next coefficient, saturated to the accumulator width.
module farrow_horner_step
   import farrow_pkg::*;
#(
   parameter int CW  = 18,
   parameter int MUW = 16
)(
   input  logic signed [CW+1:0] acc,
   input  logic        [MUW-1:0] mu,
   input  logic signed [CW-1:0]  c,
   output logic signed [CW+1:0] acc_next
);

   logic signed [63:0] acc_x;
   logic signed [63:0] mu_x;
   logic signed [63:0] c_x;
   logic signed [63:0] prod;
   logic signed [63:0] sum;

   always_comb begin
      acc_x    = {{(62 - CW){acc[CW+1]}}, acc};
      mu_x     = {{(64 - MUW){1'b0}}, mu};
      c_x      = {{(64 - CW){c[CW-1]}}, c};
      prod     = acc_x * mu_x;
      sum      = round_shr(prod, MUW) + c_x;
      acc_next = (CW + 2)'(sat_to(sum, CW + 2));
   end

endmodule

// File: rtl/farrow_coef_eval.sv
// Evaluates TAPS Farrow polynomials in parallel at fractional delay mu,
// one Horner step per cycle, holding the result until it is consumed.
module farrow_coef_eval
   import farrow_pkg::*;
#(
   parameter int TAPS   = 6,
   parameter int DEGREE = 4,
   parameter int CW     = 18,
   parameter int MUW    = 16,
   parameter int OW     = 18
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_we,
   input  logic [idx_w(DEGREE+1)-1:0]  cfg_deg,
   input  logic [idx_w(TAPS)-1:0]      cfg_tap,
   input  logic signed [CW-1:0]        cfg_data,
   output logic                        cfg_drop,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [MUW-1:0]              mu,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [TAPS*OW-1:0]          out_taps
);

   localparam int COEFS = DEGREE + 1;
   localparam int AW    = CW + 2;
   localparam int DW    = idx_w(COEFS);

   state_t                 state;
   logic [DW-1:0]          step;
   logic [MUW-1:0]         mu_q;
   logic signed [CW-1:0]   coef     [COEFS][TAPS];
   logic signed [AW-1:0]   acc      [TAPS];
   logic signed [AW-1:0]   nxt      [TAPS];
   logic signed [AW-1:0]   load_val [TAPS];
   logic signed [OW-1:0]   tap_load [TAPS];
   logic signed [OW-1:0]   tap_nxt  [TAPS];
   logic                   wr_ok;

   assign in_ready = (state == IDLE);

   // Writes only land while idle and not starting a job, so a job never sees a changing store.
   assign wr_ok = cfg_we && (state == IDLE) && !in_valid &&
                  (int'(cfg_deg) < COEFS) && (int'(cfg_tap) < TAPS);

   for (genvar i = 0; i < TAPS; i++) begin : g_tap
      farrow_horner_step #(.CW(CW), .MUW(MUW)) u_step (
         .acc      (acc[i]),
         .mu       (mu_q),
         .c        (coef[step][i]),
         .acc_next (nxt[i])
      );
   end

   always_comb begin
      for (int i = 0; i < TAPS; i++) begin
         load_val[i] = {{(AW - CW){coef[DEGREE][i][CW-1]}}, coef[DEGREE][i]};
         tap_load[i] = OW'(sat_to({{(64 - AW){load_val[i][AW-1]}}, load_val[i]}, OW));
         tap_nxt[i]  = OW'(sat_to({{(64 - AW){nxt[i][AW-1]}}, nxt[i]}, OW));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         step      <= '0;
         mu_q      <= '0;
         out_valid <= 1'b0;
         out_taps  <= '0;
         cfg_drop  <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            acc[i] <= '0;
            for (int k = 0; k < COEFS; k++)
               coef[k][i] <= '0;
         end
      end else begin
         cfg_drop <= cfg_we && !wr_ok;
         if (wr_ok)
            coef[cfg_deg][cfg_tap] <= cfg_data;

         case (state)
            IDLE: begin
               if (in_valid) begin
                  mu_q <= mu;
                  for (int i = 0; i < TAPS; i++)
                     acc[i] <= load_val[i];
                  if (DEGREE == 0) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     for (int i = 0; i < TAPS; i++)
                        out_taps[i*OW +: OW] <= tap_load[i];
                  end else begin
                     state <= EVAL;
                     step  <= DW'(DEGREE - 1);
                  end
               end
            end
            EVAL: begin
               for (int i = 0; i < TAPS; i++)
                  acc[i] <= nxt[i];
               if (step == '0) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
                  for (int i = 0; i < TAPS; i++)
                     out_taps[i*OW +: OW] <= tap_nxt[i];
               end else begin
                  step <= step - DW'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_farrow_coef_eval.sv
// Self-checking bench: a reference Horner model fills a scoreboard queue at
// each handshake; results are popped and compared when out_valid rises.
module tb_farrow_coef_eval;

   localparam int TAPS   = 6;
   localparam int DEGREE = 4;
   localparam int COEFS  = DEGREE + 1;
   localparam int CW     = 18;
   localparam int MUW    = 16;
   localparam int OW     = 18;
   localparam int AW     = CW + 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cfg_we;
   logic [2:0]           cfg_deg;
   logic [2:0]           cfg_tap;
   logic [CW-1:0]        cfg_data;
   logic                 cfg_drop;
   logic                 in_valid;
   logic                 in_ready;
   logic [MUW-1:0]       mu;
   logic                 out_valid;
   logic                 out_ready;
   logic [TAPS*OW-1:0]   out_taps;

   int checks   = 0;
   int failures = 0;

   longint               model_coef [COEFS][TAPS];
   logic [TAPS*OW-1:0]   exp_q [$];
   logic [TAPS*OW-1:0]   last_taps;

   farrow_coef_eval #(
      .TAPS(TAPS), .DEGREE(DEGREE), .CW(CW), .MUW(MUW), .OW(OW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_deg   (cfg_deg),
      .cfg_tap   (cfg_tap),
      .cfg_data  (cfg_data),
      .cfg_drop  (cfg_drop),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mu        (mu),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_taps  (out_taps)
   );

   always #5 clk = ~clk;

   function automatic longint clamp(input longint x, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      return (x > hi) ? hi : ((x < lo) ? lo : x);
   endfunction

   function automatic longint floor_div(input longint a, input longint b);
      if (a >= 0)
         return a / b;
      return -((-a + b - 1) / b);
   endfunction

   // Reference: Horner evaluation with round-half-up as floor((p + b/2) / b).
   function automatic longint model_tap(input int i, input longint mu_v);
      longint a;
      longint scale;
      scale = longint'(1) << MUW;
      a = model_coef[DEGREE][i];
      for (int k = DEGREE - 1; k >= 0; k--)
         a = clamp(floor_div(a * mu_v + scale / 2, scale) + model_coef[k][i], AW);
      return clamp(a, OW);
   endfunction

   function automatic longint tap_of(input logic [TAPS*OW-1:0] v, input int i);
      logic signed [OW-1:0] t;
      t = v[i*OW +: OW];
      return longint'(t);
   endfunction

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic writeCoef(input int deg, input int tap, input longint data, input bit expect_drop);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_deg  = 3'(deg);
      cfg_tap  = 3'(tap);
      cfg_data = CW'(data);
      @(negedge clk);
      cfg_we = 1'b0;
      checkOutput("cfg_drop", longint'(cfg_drop), longint'(expect_drop));
      if (!expect_drop)
         model_coef[deg][tap] = data;
   endtask

   task automatic applyStimulus(input logic [MUW-1:0] mu_in, input int hold, input bit inject);
      logic [TAPS*OW-1:0] exp_v;
      logic [TAPS*OW-1:0] got;
      int n;
      for (int i = 0; i < TAPS; i++)
         exp_v[i*OW +: OW] = OW'(model_tap(i, longint'(mu_in)));
      exp_q.push_back(exp_v);

      @(negedge clk);
      checkOutput("in_ready_idle", longint'(in_ready), 1);
      in_valid = 1'b1;
      mu       = mu_in;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mu       = ~mu_in;

      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (inject && n == 1) begin
            cfg_we   = 1'b1;
            cfg_deg  = 3'd0;
            cfg_tap  = 3'd2;
            cfg_data = CW'(999);
         end
         if (inject && n == 2) begin
            cfg_we = 1'b0;
            checkOutput("drop_in_eval", longint'(cfg_drop), 1);
         end
         if (out_valid || n >= 20)
            break;
      end
      checkOutput("out_valid_rise", longint'(out_valid), 1);
      checkOutput("latency", longint'(n), DEGREE + 1);

      got       = out_taps;
      last_taps = got;
      exp_v     = exp_q.pop_front();
      for (int i = 0; i < TAPS; i++)
         checkOutput($sformatf("tap%0d", i), tap_of(got, i), tap_of(exp_v, i));

      for (int k = 0; k < hold; k++) begin
         in_valid = (k % 2 == 0);
         @(negedge clk);
         checkOutput("hold_valid", longint'(out_valid), 1);
         checkOutput("hold_in_ready", longint'(in_ready), 0);
         checkOutput("hold_stable", longint'(out_taps == got), 1);
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("release_valid", longint'(out_valid), 0);
      checkOutput("release_ready", longint'(in_ready), 1);
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      cfg_deg   = '0;
      cfg_tap   = '0;
      cfg_data  = '0;
      in_valid  = 1'b0;
      mu        = '0;
      out_ready = 1'b0;
      for (int k = 0; k < COEFS; k++)
         for (int i = 0; i < TAPS; i++)
            model_coef[k][i] = 0;

      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", longint'(in_ready), 1);
      checkOutput("rst_out_valid", longint'(out_valid), 0);
      checkOutput("rst_out_taps_zero", longint'(out_taps == '0), 1);
      checkOutput("rst_cfg_drop", longint'(cfg_drop), 0);
      rst_n = 1'b1;

      // Constant polynomial: every tap 1.0 regardless of mu.
      for (int i = 0; i < TAPS; i++)
         writeCoef(0, i, 65536, 1'b0);
      applyStimulus(16'h1234, 0, 1'b0);
      checkOutput("const_tap3", tap_of(last_taps, 3), 65536);

      // Linear on tap 0, quadratic on tap 1, at mu = 0.5.
      writeCoef(0, 0, 0, 1'b0);
      writeCoef(0, 1, 0, 1'b0);
      writeCoef(1, 0, 65536, 1'b0);
      writeCoef(2, 1, 65536, 1'b0);
      applyStimulus(16'h8000, 0, 1'b0);
      checkOutput("lin_tap0", tap_of(last_taps, 0), 32768);
      checkOutput("quad_tap1", tap_of(last_taps, 1), 16384);

      // Saturation, positive then negative with backpressure.
      writeCoef(2, 1, 0, 1'b0);
      writeCoef(0, 0, 131071, 1'b0);
      writeCoef(1, 0, 131071, 1'b0);
      applyStimulus(16'hFFFF, 0, 1'b0);
      checkOutput("sat_pos_tap0", tap_of(last_taps, 0), 131071);
      writeCoef(0, 0, -131072, 1'b0);
      writeCoef(1, 0, -131072, 1'b0);
      applyStimulus(16'hFFFF, 6, 1'b0);
      checkOutput("sat_neg_tap0", tap_of(last_taps, 0), -131072);

      // Rejected writes: bad tap, bad degree, and a write during EVAL.
      writeCoef(0, 7, 12345, 1'b1);
      writeCoef(5, 0, 12345, 1'b1);
      applyStimulus(16'h5555, 0, 1'b1);
      applyStimulus(16'h0000, 0, 1'b0);
      checkOutput("readback_tap2", tap_of(last_taps, 2), 65536);
      checkOutput("readback_tap0", tap_of(last_taps, 0), -131072);

      for (int r = 0; r < 3; r++) begin
         writeCoef(int'($urandom_range(0, COEFS - 1)), int'($urandom_range(0, TAPS - 1)),
                   longint'($urandom_range(0, 262143)) - 131072, 1'b0);
         writeCoef(int'($urandom_range(0, COEFS - 1)), int'($urandom_range(0, TAPS - 1)),
                   longint'($urandom_range(0, 262143)) - 131072, 1'b0);
         applyStimulus(MUW'($urandom_range(0, 65535)), r, 1'b0);
      end

      // Reset during EVAL step 2 abandons the job and clears the store.
      @(negedge clk);
      in_valid = 1'b1;
      mu       = 16'h7777;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", longint'(out_valid), 0);
      checkOutput("midrst_out_taps_zero", longint'(out_taps == '0), 1);
      checkOutput("midrst_in_ready", longint'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < COEFS; k++)
         for (int i = 0; i < TAPS; i++)
            model_coef[k][i] = 0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid)
            seen++;
      end
      checkOutput("midrst_no_valid", longint'(seen), 0);
      applyStimulus(16'h4321, 0, 1'b0);
      checkOutput("zero_store_tap0", tap_of(last_taps, 0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
